// File: rtl/snitch_acc_offload.sv
// Core-side accelerator offload initiator: one-entry request register toward the
// accelerator, destination-register scoreboard, and a pass-through writeback path.
package snitch_pkg;
   localparam int unsigned FLEN = 32;

   typedef struct packed {
      logic [31:0]     data_op;
      logic [FLEN-1:0] data_arga;
      logic [FLEN-1:0] data_argb;
      logic [FLEN-1:0] data_argc;
   } acc_req_t;

   typedef struct packed {
      logic [4:0]      id;
      logic [FLEN-1:0] data;
      logic            error;
   } acc_resp_t;
endpackage

module snitch_acc_offload #(
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned DataWidth      = snitch_pkg::FLEN
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_op_i,
   input  logic [DataWidth-1:0]  issue_arga_i,
   input  logic [DataWidth-1:0]  issue_argb_i,
   input  logic [DataWidth-1:0]  issue_argc_i,
   output snitch_pkg::acc_req_t  acc_req_o,
   output logic                  acc_req_valid_o,
   input  logic                  acc_req_ready_i,
   input  snitch_pkg::acc_resp_t acc_resp_i,
   input  logic                  acc_resp_valid_i,
   output logic                  acc_resp_ready_o,
   output logic                  wb_valid_o,
   input  logic                  wb_ready_i,
   output logic [4:0]            wb_rd_o,
   output logic [DataWidth-1:0]  wb_data_o,
   output logic                  wb_error_o,
   output logic [31:0]           pending_o,
   output logic                  busy_o
);
   localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   typedef enum logic {Empty, Full} oreg_e;

   oreg_e                state_q, state_d;
   snitch_pkg::acc_req_t req_q, req_d;
   logic [31:0]          sb_q, sb_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [4:0]           rd, rs1, rs2, rs3;
   logic                 hazard, issue_hs, resp_hs;

   assign rd  = issue_op_i[11:7];
   assign rs1 = issue_op_i[19:15];
   assign rs2 = issue_op_i[24:20];
   assign rs3 = issue_op_i[31:27];

   // Sources are checked on every op regardless of format; bit 0 is never set.
   assign hazard = sb_q[rd] | sb_q[rs1] | sb_q[rs2] | sb_q[rs3];

   assign issue_ready_o = !rst_i && (state_q == Empty || acc_req_ready_i)
                          && (cnt_q < MaxCnt) && !hazard;
   assign issue_hs      = issue_valid_i && issue_ready_o;

   // Only responses that match an outstanding destination touch the bookkeeping.
   assign resp_hs = acc_resp_valid_i && wb_ready_i && sb_q[acc_resp_i.id] && (cnt_q != '0);

   assign wb_valid_o       = acc_resp_valid_i;
   assign wb_rd_o          = acc_resp_i.id;
   assign wb_data_o        = acc_resp_i.data;
   assign wb_error_o       = acc_resp_i.error;
   assign acc_resp_ready_o = wb_ready_i;

   assign acc_req_valid_o = (state_q == Full);
   assign acc_req_o       = req_q;
   assign pending_o       = sb_q;
   assign busy_o          = (cnt_q != '0);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;

      case (state_q)
         Empty: if (issue_hs) state_d = Full;
         Full:  if (!issue_hs && acc_req_ready_i) state_d = Empty;
         default: state_d = Empty;
      endcase

      if (issue_hs) begin
         req_d.data_op   = issue_op_i;
         req_d.data_arga = issue_arga_i;
         req_d.data_argb = issue_argb_i;
         req_d.data_argc = issue_argc_i;
      end

      if (resp_hs) begin
         sb_d[acc_resp_i.id] = 1'b0;
         cnt_d               = cnt_d - 1'b1;
      end
      if (issue_hs) begin
         if (rd != 5'd0) sb_d[rd] = 1'b1;
         cnt_d = cnt_d + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= Empty;
         req_q   <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
      end
   end

   spurious_resp: assert property (@(posedge clk_i) disable iff (rst_i)
      (acc_resp_valid_i && wb_ready_i) |-> (sb_q[acc_resp_i.id] && cnt_q != '0))
      else $warning("spurious accelerator response id=%0d", acc_resp_i.id);

endmodule

// File: doc/snitch_acc_offload.md
Name: snitch_acc_offload

Overview:
Core-side initiator for the accelerator interface. It takes decoded offload instructions and their operand values from the integer pipeline, drives acc_req to an accelerator (e.g. the FP subsystem), and tracks pending destination registers in a scoreboard. It accepts acc_resp and turns it into an integer-regfile writeback, and stalls issue on hazards and on the outstanding-request limit.

Parameters:
MaxOutstanding, 4, max requests issued (incl. one held in output register) without response; 1..15
DataWidth, 32, operand/result width (FLEN)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
issue_valid_i  in  1  offload instruction valid
issue_ready_o  out  1  offload instruction accepted
issue_op_i  in  32  raw instruction word
issue_arga_i / issue_argb_i / issue_argc_i  in  DataWidth each  operand values (rs1/rs2/rs3)
acc_req_o  out  snitch_pkg::acc_req_t  fields data_op, data_arga, data_argb, data_argc
acc_req_valid_o  out  1  request valid
acc_req_ready_i  in  1  accelerator accepts
acc_resp_i  in  snitch_pkg::acc_resp_t  fields id[4:0], data, error
acc_resp_valid_i  in  1  response valid
acc_resp_ready_o  out  1  response accepted
wb_valid_o  out  1  regfile write valid
wb_ready_i  in  1  regfile write port free
wb_rd_o  out  5  destination register
wb_data_o  out  DataWidth  write data
wb_error_o  out  1  accelerator error flag
pending_o  out  32  scoreboard bitmap (bit i = x_i awaiting result)
busy_o  out  1  outstanding count != 0

Behaviour:
- Reset (sync, rst_i high at posedge): scoreboard=0, count=0, output register empty. acc_req_valid_o=0, pending_o=0, busy_o=0, issue_ready_o=0 while rst_i high. Reset mid-transaction drops held request and all pending state; late responses after reset are spurious (below).
- Field decode: rd=op[11:7], rs1=op[19:15], rs2=op[24:20], rs3=op[31:27]. Register 0 never pending; rd=0 never set in scoreboard.
- Output register, two states: EMPTY, FULL. EMPTY->FULL on issue handshake. FULL->EMPTY on acc_req handshake without new issue. FULL->FULL when both occur in the same cycle (new contents loaded). Issue-to-acc_req_valid_o latency: 1 cycle. acc_req_o stable while valid && !ready.
- issue_ready_o = !rst_i && (EMPTY || acc_req_ready_i) && count < MaxOutstanding && !hazard.
- hazard = registered scoreboard bit set for rd, rs1, rs2 or rs3. All three source fields are checked for every op (conservative). No same-cycle bypass: an instruction whose register is freed by a response this cycle issues next cycle at earliest.
- Issue handshake: set scoreboard[rd] (if rd!=0), count+1.
- Response path is combinational pass-through: wb_valid_o=acc_resp_valid_i, wb_rd_o=id, wb_data_o=data, wb_error_o=error, acc_resp_ready_o=wb_ready_i. Responses are accepted in any order.
- Response handshake: clear scoreboard[id], count-1.
- Simultaneous issue and response: count unchanged. Set and clear on different bits both apply.
- Spurious response (id bit not set, or count==0): still forwarded to writeback. Scoreboard and count unchanged (no underflow). Simulation assertion fires.
- busy_o=(count!=0). pending_o=registered scoreboard.

Test Plan:
- Reset, then issue FADD_S rd=x5 arga=0x3F800000 argb=0x40000000 -> acc_req_valid_o=1 next cycle with those fields; pending_o=0x20; busy_o=1. Response id=5 data=0x40400000 -> wb_valid_o=1, wb_rd_o=5, wb_data_o=0x40400000; pending_o=0 next cycle.
- RAW: issue rd=x6, then op with rs1=x6 -> issue_ready_o=0 until the cycle after response id=6 handshakes, then accepted.
- Limit with MaxOutstanding=4: issue 4 ops to rd x1..x4 with no responses -> fifth (rd x7) stalled. One response -> fifth accepted the following cycle; count stays 4.
- Backpressure: acc_req_ready_i=0 for 3 cycles -> acc_req_o unchanged, issue_ready_o=0. Ready rises in the same cycle as a new valid issue -> back-to-back transfer, no bubble.
- Simultaneous issue rd=x8 and response id=3 -> pending_o sets bit8, clears bit3; count unchanged. Response id=9 not pending -> forwarded to writeback, assertion fires, count unchanged.
- rst_i asserted with 2 pending and request held -> next cycle acc_req_valid_o=0, pending_o=0, busy_o=0. wb_ready_i=0 during a response -> acc_resp_ready_o=0 and scoreboard bit held.
